// File: rtl/lsu_ld_engine.sv
// rtl/lsu_ld_engine.sv - strided AXI read load engine writing returned beats into on-chip SRAM
module lsu_ld_engine #(
    parameter int AXI_DW  = 32,
    parameter int SRAM_AW = 8,
    parameter int ID_W    = 8,
    parameter int MAX_OUT = 4,
    parameter int NUM_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cmd_vld,
    output logic               cmd_rdy,
    input  logic [ID_W-1:0]    cmd_id,
    input  logic [30:0]        cmd_dram_addr,
    input  logic [7:0]         cmd_len,
    input  logic [NUM_W-1:0]   cmd_num,
    input  logic [15:0]        cmd_str,
    input  logic [SRAM_AW-1:0] cmd_sram_addr,

    output logic [ID_W-1:0]    axi_arid,
    output logic [30:0]        axi_araddr,
    output logic [7:0]         axi_arlen,
    output logic [2:0]         axi_arsize,
    output logic [1:0]         axi_arburst,
    output logic               axi_arvalid,
    input  logic               axi_arready,

    input  logic [ID_W-1:0]    axi_rid,
    input  logic [AXI_DW-1:0]  axi_rdata,
    input  logic [1:0]         axi_rresp,
    input  logic               axi_rlast,
    input  logic               axi_rvalid,
    output logic               axi_rready,

    output logic               sram_cen,
    output logic               sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [AXI_DW-1:0]  sram_din,

    output logic               busy,
    output logic               done,
    output logic               err
);

    // Outstanding counter must hold the value MAX_OUT itself.
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0]       AR_SIZE = 3'($clog2(AXI_DW / 8));
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    logic [1:0]         state_q,   state_d;
    logic [ID_W-1:0]    id_q,      id_d;
    logic [30:0]        addr_q,    addr_d;
    logic [7:0]         len_q,     len_d;
    logic [NUM_W-1:0]   num_q,     num_d;
    logic [15:0]        str_q,     str_d;
    logic [NUM_W-1:0]   row_q,     row_d;
    logic [OUT_W-1:0]   out_q,     out_d;
    logic [SRAM_AW-1:0] wptr_q,    wptr_d;
    logic               err_q,     err_d;
    logic               done_q,    done_d;
    logic               wr_vld_q,  wr_vld_d;
    logic [SRAM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_DW-1:0]  wr_data_q, wr_data_d;

    logic cmd_acc;
    logic ar_vld;
    logic ar_hs;
    logic r_rdy;
    logic r_match;
    logic r_end;

    // Handshake decode, counters, address stepping and next-state logic.
    always_comb begin
        cmd_acc = (state_q == S_IDLE) && cmd_vld;
        ar_vld  = (state_q == S_ISSUE) && (out_q < OUT_MAX);
        ar_hs   = ar_vld && axi_arready;
        r_rdy   = (state_q != S_IDLE);
        // Foreign-ID beats are consumed but never written or counted.
        r_match = axi_rvalid && r_rdy && (axi_rid == id_q);
        r_end   = r_match && axi_rlast && (out_q != '0);

        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        num_d     = num_q;
        str_d     = str_q;
        row_d     = row_q;
        out_d     = out_q;
        wptr_d    = wptr_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_vld_d  = r_match;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (cmd_acc) begin
            id_d   = cmd_id;
            addr_d = cmd_dram_addr;
            len_d  = cmd_len;
            num_d  = cmd_num;
            str_d  = cmd_str;
            row_d  = '0;
            out_d  = '0;
            wptr_d = cmd_sram_addr;
            err_d  = 1'b0;
        end

        // Row address advances only on a handshake so the AR payload holds under backpressure.
        if (ar_hs) begin
            addr_d = addr_q + {15'b0, str_q};
            row_d  = row_q + NUM_W'(1);
        end

        case ({ar_hs, r_end})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: ;
        endcase

        if (r_match) begin
            wr_addr_d = wptr_q;
            wr_data_d = axi_rdata;
            wptr_d    = wptr_q + SRAM_AW'(1);
            if (axi_rresp != 2'b00) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_hs && (row_q == num_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset returns every output to its idle value.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            num_q     <= '0;
            str_q     <= '0;
            row_q     <= '0;
            out_q     <= '0;
            wptr_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            num_q     <= num_d;
            str_q     <= str_d;
            row_q     <= row_d;
            out_q     <= out_d;
            wptr_q    <= wptr_d;
            err_q     <= err_d;
            done_q    <= done_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign cmd_rdy     = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;

    assign axi_arid    = id_q;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = AR_SIZE;
    assign axi_arburst = 2'b01;
    assign axi_arvalid = ar_vld;
    assign axi_rready  = r_rdy;

    assign sram_cen    = wr_vld_q;
    assign sram_wen    = wr_vld_q;
    assign sram_addr   = wr_addr_q;
    assign sram_din    = wr_data_q;

endmodule

// File: tb/tb_lsu_ld_engine.sv
// tb/tb_lsu_ld_engine.sv - scoreboard bench for lsu_ld_engine with randomized commands
module tb_lsu_ld_engine;
    localparam int AXI_DW  = 32;
    localparam int SRAM_AW = 8;
    localparam int ID_W    = 8;
    localparam int MAX_OUT = 4;
    localparam int NUM_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [7:0]  cmd_id = '0;
    logic [30:0] cmd_dram_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_num = '0;
    logic [15:0] cmd_str = '0;
    logic [7:0]  cmd_sram_addr = '0;
    logic [7:0]  axi_arid;
    logic [30:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_rid = '0;
    logic [31:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0;
    logic        axi_rlast = 1'b0;
    logic        axi_rvalid = 1'b0;
    logic        axi_rready;
    logic        sram_cen;
    logic        sram_wen;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    lsu_ld_engine #(
        .AXI_DW(AXI_DW), .SRAM_AW(SRAM_AW), .ID_W(ID_W), .MAX_OUT(MAX_OUT), .NUM_W(NUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_id(cmd_id), .cmd_dram_addr(cmd_dram_addr),
        .cmd_len(cmd_len), .cmd_num(cmd_num), .cmd_str(cmd_str), .cmd_sram_addr(cmd_sram_addr),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct { logic [30:0] addr; logic [7:0] len; logic [7:0] id; } ar_t;
    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

    ar_t ar_q[$];
    wr_t wr_q[$];
    int  ar_cyc[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  ar_hs_cnt = 0;
    int  ar_mode = 0;
    bit  ar_man = 1'b0;
    bit  done_ok = 1'b0;
    int  done_cnt = 0;
    int  cmds_done = 0;
    bit  err_exp = 1'b0;
    bit  hold_pend = 1'b0;
    logic [30:0] hold_addr = '0;
    logic [7:0]  wptr_m = '0;
    logic [7:0]  cur_id = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave AR ready: 0 = always ready, 1 = random, 2 = manual
    initial begin
        axi_arready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ar_mode == 0)      axi_arready = 1'b1;
            else if (ar_mode == 1) axi_arready = 1'($urandom_range(0, 1));
            else                   axi_arready = ar_man;
        end
    end

    // AR monitor: scoreboard pop and payload stability
    always @(negedge clk) begin
        ar_t e;
        if (!rst_n && hold_pend) begin
            check("ar_hold_valid", axi_arvalid, 1);
            check("ar_hold_addr", axi_araddr, hold_addr);
        end
        if (!rst_n && axi_arvalid && axi_arready) begin
            check("ar_expected", ar_q.size() != 0, 1);
            if (ar_q.size() != 0) begin
                e = ar_q.pop_front();
                check("araddr", axi_araddr, e.addr);
                check("arlen", axi_arlen, e.len);
                check("arid", axi_arid, e.id);
            end
            check("arsize", axi_arsize, 3'd2);
            check("arburst", axi_arburst, 2'b01);
            ar_hs_cnt++;
            ar_cyc.push_back(cyc);
        end
        hold_pend = !rst_n && axi_arvalid && !axi_arready;
        hold_addr = axi_araddr;
    end

    // SRAM write and done monitor
    always @(negedge clk) begin
        wr_t w;
        if (sram_cen || sram_wen) begin
            check("sram_cen_eq_wen", sram_cen, sram_wen);
            check("sram_write_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("sram_addr", sram_addr, w.addr);
                check("sram_din", sram_din, w.data);
            end
        end
        if (done) begin
            check("done_expected", done_ok, 1);
            done_ok = 1'b0;
            done_cnt++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_rdy"}, cmd_rdy, 1);
        check({tag, "_arvalid"}, axi_arvalid, 0);
        check({tag, "_rready"}, axi_rready, 0);
        check({tag, "_sram_cen"}, sram_cen, 0);
        check({tag, "_sram_wen"}, sram_wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_araddr"}, axi_araddr, 0);
        check({tag, "_arid"}, axi_arid, 0);
        check({tag, "_arlen"}, axi_arlen, 0);
    endtask

    task automatic issue(input logic [7:0] id, input logic [30:0] addr, input logic [7:0] len,
                         input logic [3:0] num, input logic [15:0] str, input logic [7:0] saddr);
        ar_t e;
        int  t = 0;
        while (!cmd_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cmd_rdy_before_issue", cmd_rdy, 1);
        ar_hs_cnt = 0;
        ar_cyc.delete();
        for (int r = 0; r <= int'(num); r++) begin
            e.addr = 31'(longint'(addr) + longint'(r) * longint'(str));
            e.len  = len;
            e.id   = id;
            ar_q.push_back(e);
        end
        cur_id  = id;
        wptr_m  = saddr;
        err_exp = 1'b0;
        cmd_id = id; cmd_dram_addr = addr; cmd_len = len; cmd_num = num;
        cmd_str = str; cmd_sram_addr = saddr; cmd_vld = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        check("busy_after_accept", busy, 1);
        check("cmd_rdy_after_accept", cmd_rdy, 0);
        check("arvalid_after_accept", axi_arvalid, 1);
        check("err_cleared", err, 0);
    endtask

    task automatic wait_ar(input int n);
        int t = 0;
        while (ar_hs_cnt < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("ar_arrival", ar_hs_cnt >= n, 1);
    endtask

    task automatic r_beat(input logic [7:0] id, input bit last, input logic [1:0] resp);
        logic [31:0] d;
        wr_t w;
        d = $urandom;
        axi_rid = id; axi_rdata = d; axi_rresp = resp; axi_rlast = last; axi_rvalid = 1'b1;
        if (id == cur_id) begin
            w.addr = wptr_m;
            w.data = d;
            wr_q.push_back(w);
            wptr_m = wptr_m + 8'd1;
            if (resp != 2'b00) err_exp = 1'b1;
        end
        @(negedge clk);
        check("rready", axi_rready, 1);
        @(posedge clk);
        #1;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    task automatic return_burst(input int len, input bit is_final, input int err_idx, input bit rnd);
        logic [1:0] resp;
        for (int k = 0; k <= len; k++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 5) == 0) r_beat(cur_id ^ 8'h80, 1'b1, 2'b00);
            end
            resp = (k == err_idx) ? 2'b10 : 2'b00;
            if (rnd && $urandom_range(0, 7) == 0) resp = 2'($urandom_range(1, 3));
            if (is_final && k == len) done_ok = 1'b1;
            r_beat(cur_id, k == len, resp);
            if (k == err_idx && k != len) begin
                @(negedge clk);
                check("err_set_after_beat", err, 1);
                @(posedge clk);
                #1;
            end
        end
        if (is_final) begin
            @(negedge clk);
            check("done_after_rlast", done, 1);
            check("busy_after_rlast", busy, 0);
            check("cmd_rdy_after_rlast", cmd_rdy, 1);
            check("err_at_done", err, err_exp);
            cmds_done++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single row
        ar_mode = 0;
        issue(8'h05, 31'h100, 8'd3, 4'd0, 16'h0, 8'h10);
        wait_ar(1);
        return_burst(3, 1'b1, -1, 1'b0);

        // strided rows, back-to-back AR
        issue(8'h06, 31'h1000, 8'd0, 4'd3, 16'h40, 8'h30);
        wait_ar(4);
        for (int i = 0; i < 3; i++) check("ar_back_to_back", ar_cyc[i + 1] - ar_cyc[i], 1);
        for (int b = 0; b < 4; b++) return_burst(0, b == 3, -1, 1'b0);

        // outstanding limit
        issue(8'h07, 31'h2000, 8'd1, 4'd5, 16'h20, 8'h50);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("out_limit_ar_count", ar_hs_cnt, MAX_OUT);
        check("out_limit_arvalid", axi_arvalid, 0);
        for (int b = 0; b < 6; b++) begin
            wait_ar(b + 1);
            return_burst(1, b == 5, -1, 1'b0);
            if (b == 0) begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                check("out_release_one", ar_hs_cnt, MAX_OUT + 1);
            end
        end

        // SRAM wrap and error response
        issue(8'h11, 31'h2000, 8'd3, 4'd0, 16'h0, 8'hFE);
        wait_ar(1);
        return_burst(3, 1'b1, 1, 1'b0);
        check("err_sticky_model", err_exp, 1);

        // foreign ID and simultaneous AR + rlast
        ar_mode = 2;
        ar_man  = 1'b0;
        issue(8'h22, 31'h3000, 8'd1, 4'd1, 16'h100, 8'h20);
        check("err_cleared_next_cmd", err, 0);
        ar_man = 1'b1;
        wait_ar(1);
        ar_man = 1'b0;
        r_beat(8'h55, 1'b1, 2'b00);
        r_beat(cur_id, 1'b0, 2'b00);
        ar_man = 1'b1;
        r_beat(cur_id, 1'b1, 2'b00);
        ar_man = 1'b0;
        check("simul_ar_count", ar_hs_cnt, 2);
        repeat (3) begin
            @(negedge clk);
            check("simul_no_early_done", done, 0);
        end
        check("simul_busy", busy, 1);
        @(posedge clk);
        #1;
        return_burst(1, 1'b1, -1, 1'b0);
        ar_mode = 0;

        // reset mid-command with two bursts outstanding
        issue(8'h44, 31'h4000, 8'd3, 4'd1, 16'h80, 8'h80);
        wait_ar(2);
        @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b1;
        #1;
        check_reset_vals("midrst");
        ar_q.delete();
        wr_q.delete();
        axi_rid = 8'h44; axi_rvalid = 1'b1; axi_rlast = 1'b0; cur_id = 8'h00;
        @(negedge clk);
        check("rready_in_reset", axi_rready, 0);
        @(posedge clk);
        #1;
        axi_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        issue(8'h45, 31'h5000, 8'd2, 4'd0, 16'h0, 8'h40);
        wait_ar(1);
        return_burst(2, 1'b1, -1, 1'b0);

        // randomized commands
        ar_mode = 1;
        for (int n = 0; n < 8; n++) begin
            logic [3:0] num;
            logic [7:0] len;
            num = 4'($urandom_range(0, 5));
            len = 8'($urandom_range(0, 3));
            issue(8'($urandom_range(0, 127)), 31'($urandom) & ~31'h3, len, num,
                  16'($urandom) & ~16'h3, 8'($urandom));
            for (int b = 0; b <= int'(num); b++) begin
                wait_ar(b + 1);
                return_burst(int'(len), b == int'(num), -1, 1'b1);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("done_count", done_cnt, cmds_done);
        check("ar_queue_empty", ar_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_ld_engine.md
# lsu_ld_engine

Parametrised AXI read load engine for the LSU. It takes one strided load command from the instruction decoder and issues a sequence of INCR read bursts, one per row, with a bounded number of bursts in flight. It writes every returned beat into an on-chip SRAM (IRAM or WRAM) through a single write port. It replaces the fixed single-burst load path: AXI data width, SRAM depth, ID width and maximum outstanding bursts are configurable, and it adds multi-row strides and error tracking.

## Interface
- AXI_DW, 32, AXI read data width and SRAM word width in bits; power of two, 32..256
- SRAM_AW, 8, SRAM word-address width
- ID_W, 8, AXI ID width
- MAX_OUT, 4, maximum AR bursts in flight; 1..15
- NUM_W, 4, width of the row-count field
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-high reset (asserted when 1)
- cmd_vld  in  1  load command valid
- cmd_rdy  out  1  engine idle and able to accept a command
- cmd_id  in  ID_W  AXI ID used for every burst of this command
- cmd_dram_addr  in  31  byte address of row 0; AXI_DW/8-aligned
- cmd_len  in  8  beats per row minus 1; driven onto ARLEN
- cmd_num  in  NUM_W  rows minus 1
- cmd_str  in  16  byte stride between row start addresses
- cmd_sram_addr  in  SRAM_AW  first SRAM word written
- axi_arid / araddr / arlen / arsize / arburst / arvalid  out  ID_W/31/8/3/2/1  AR channel; arsize = log2(AXI_DW/8), arburst = 2'b01
- axi_arready  in  1
- axi_rid / rdata / rresp / rlast / rvalid  in  ID_W/AXI_DW/2/1/1  R channel
- axi_rready  out  1
- sram_cen / sram_wen  out  1/1  write strobe; both high for one cycle per written word
- sram_addr / sram_din  out  SRAM_AW/AXI_DW
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky: any rresp != 0 since the last accepted command

## Operation
- FSM: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: cmd_rdy=1. On cmd_vld, latch all cmd_* fields, clear err, clear row and beat counters, and go to ISSUE.
- ISSUE: arvalid=1 while rows remain and outstanding < MAX_OUT.
  - araddr = dram_addr + row*str, computed mod 2^31.
  - The AR payload stays stable while arvalid=1 and arready=0.
  - Each AR handshake increments row and outstanding.
  - After the handshake for row cmd_num, go to DRAIN.
- Outstanding counter:
  - +1 on an AR handshake.
  - −1 on an R handshake with rlast.
  - Both in the same cycle: no change.
  - Never exceeds MAX_OUT.
- R path: axi_rready=1 in ISSUE and DRAIN, 0 in IDLE.
  - A beat with rid == latched id is written to SRAM at wptr. wptr starts at cmd_sram_addr, increments by 1 per beat, and wraps mod 2^SRAM_AW.
  - A beat with rid != latched id is accepted and discarded. It does not advance wptr and does not affect outstanding, even if rlast=1.
- Error: rresp != 0 on a matching beat sets err. The data is still written and the command still completes.
- DRAIN: when outstanding reaches 0 (after the final rlast), go to IDLE and pulse done.
- A 4 KB-crossing burst is a caller error. The engine issues it unchanged.
- Reset (any time): FSM to IDLE; the counters, outstanding, wptr and err are all cleared; all outputs return to their reset values. Beats still in flight from before reset are not written (rready=0 in IDLE).

## Timing
- Reset values:
  - cmd_rdy=1.
  - arvalid=0, rready=0, sram_cen=0, sram_wen=0, busy=0, done=0, err=0.
  - araddr/arid/arlen = 0.
- Command accepted at cycle T → busy=1, cmd_rdy=0 and first arvalid=1 at T+1.
- Back-to-back AR: after a handshake at cycle C, the next row's arvalid is high at C+1 if outstanding (updated) < MAX_OUT.
- SRAM write is registered: an R handshake at cycle C gives sram_cen=sram_wen=1 with that beat's addr/data at C+1.
- Final rlast handshake at cycle L:
  - At L+1: last SRAM write, done=1, busy=0, cmd_rdy=1.
  - A new command may be accepted at L+1.
- err updates in the cycle after the offending beat and holds until the next command is accepted.

## Test plan
- Single row: num=0, len=3, addr=0x100, sram_addr=0x10 → one AR (araddr 0x100, arlen 3), four SRAM writes to 0x10..0x13, done one cycle after rlast.
- Strided rows: num=3, len=0, str=0x40, addr=0x1000, arready always 1 → araddr 0x1000/0x1040/0x1080/0x10C0 on four consecutive cycles; SRAM addresses are consecutive.
- Outstanding limit: MAX_OUT=2, num=4, R withheld → exactly 2 ARs and then arvalid=0; each rlast releases one more AR; 5 ARs total.
- Wrap and errors: SRAM_AW=8, sram_addr=0xFE, len=3 → writes to 0xFE, 0xFF, 0x00, 0x01. The second beat has rresp=2'b10 → err=1 after that beat, done still pulses, err is cleared on the next command.
- Foreign ID and simultaneous events: inject an rid-mismatch beat with rlast=1 → no SRAM write and outstanding unchanged. Then align an AR handshake with a matching rlast → outstanding unchanged.
- Reset mid-command: assert rst_n during DRAIN with 2 bursts outstanding → all outputs return to reset values immediately; the next command runs cleanly from the new sram_addr.
